q_bridge_sequencer: RTL and testbench

Echo-train sequencer for the H-bridge pulse generator that drives the Q1Q8/Q3Q6 switch pairs. On a host start it latches a configuration, delivers the 16-bit pulse-timing word to the generator with a double load strobe so the generator's two-stage width registers settle, then runs the generator for a programmed number of echo periods. Between echoes it holds the generator in reset so its internal count re-arms. It provides per-echo sync and completion status to the acquisition controller.

---
 rtl/q_bridge_sequencer_if.sv | 24 ++
 rtl/q_bridge_sequencer.sv | 68 ++++++
 tb/tb_q_bridge_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/q_bridge_sequencer_if.sv
// q_bridge_sequencer_if: host and pulse-generator signal bundle for the echo-train sequencer
interface q_bridge_sequencer_if;
    logic        i_start;
    logic        i_abort;
    logic [15:0] i_cfg_word;
    logic [7:0]  i_cfg_count;
    logic [15:0] i_cfg_period;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic [15:0] o_pg_datain;
    logic        o_pg_load;
    logic        o_pg_rst_n;
    logic        o_sync;
    logic [7:0]  o_echo_idx;
    modport master (
        output i_start, i_abort, i_cfg_word, i_cfg_count, i_cfg_period,
        input  o_busy, o_done, o_err, o_pg_datain, o_pg_load, o_pg_rst_n, o_sync, o_echo_idx
    );
    modport slave (
        input  i_start, i_abort, i_cfg_word, i_cfg_count, i_cfg_period,
        output o_busy, o_done, o_err, o_pg_datain, o_pg_load, o_pg_rst_n, o_sync, o_echo_idx
    );
endinterface

// File: rtl/q_bridge_sequencer.sv
// q_bridge_sequencer: loads the H-bridge pulse generator with a double strobe, then runs a re-armed echo train
module q_bridge_sequencer #(
    parameter int LOAD_HIGH = 2,
    parameter int LOAD_GAP  = 2,
    parameter int REARM     = 2
) (
    input logic clk,
    input logic reset,
    q_bridge_sequencer_if.slave bus
);
    localparam logic [15:0] STROBE_LEN = 16'(LOAD_HIGH + LOAD_GAP);
    localparam logic [15:0] LOAD_LEN   = 16'(2 * (LOAD_HIGH + LOAD_GAP));
    localparam logic [15:0] HIGH_LEN   = 16'(LOAD_HIGH);
    localparam logic [15:0] REARM_LEN  = 16'(REARM);
    typedef enum logic [2:0] {IDLE, LOAD, RUN, REARM_ST, DONE} state_t;
    state_t r_state, w_next;
    logic [15:0] r_cnt, r_word, r_period, w_limit;
    logic [7:0]  r_count, r_idx;
    logic        r_err, w_req, w_reject, w_accept, w_end, w_last;
    logic [16:0] w_min_period;
    assign w_min_period = 17'(bus.i_cfg_word[15:10]) + 17'(REARM) + 17'd3;
    assign w_req        = r_state == IDLE && bus.i_start && !bus.i_abort;
    assign w_reject     = w_req && (bus.i_cfg_count == 8'd0 || {1'b0, bus.i_cfg_period} < w_min_period);
    assign w_accept     = w_req && !w_reject;
    assign w_limit      = r_state == LOAD ? LOAD_LEN : r_state == RUN ? r_period - REARM_LEN : REARM_LEN;
    assign w_end        = r_cnt == w_limit - 16'd1;
    assign w_last       = r_idx == r_count - 8'd1;
    always_comb begin
        w_next = bus.i_abort ? IDLE
               : r_state == IDLE ? (w_accept ? LOAD : IDLE)
               : r_state == DONE ? IDLE
               : !w_end ? r_state
               : r_state == LOAD ? RUN
               : r_state == RUN ? REARM_ST
               : w_last ? DONE : RUN;
        bus.o_busy      = r_state != IDLE;
        bus.o_done      = r_state == DONE;
        bus.o_err       = r_err;
        bus.o_pg_datain = r_word;
        bus.o_pg_load   = r_state == LOAD && (r_cnt < HIGH_LEN || (r_cnt >= STROBE_LEN && r_cnt < STROBE_LEN + HIGH_LEN));
        bus.o_pg_rst_n  = r_state == RUN;
        bus.o_sync      = r_state == RUN && r_cnt == 16'd0;
        bus.o_echo_idx  = r_idx;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_word   <= '0;
            r_period <= '0;
            r_count  <= '0;
            r_idx    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state || r_state == IDLE) ? '0 : r_cnt + 16'd1;
            r_err   <= w_reject;
            if (w_accept) begin
                r_word   <= bus.i_cfg_word;
                r_count  <= bus.i_cfg_count;
                r_period <= bus.i_cfg_period;
                r_idx    <= '0;
            end else if (r_state == REARM_ST && w_next == RUN) begin
                r_idx <= r_idx + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_q_bridge_sequencer.sv
// tb_q_bridge_sequencer: scoreboard bench comparing the sequencer against a cycle-timeline model
module tb_q_bridge_sequencer;
    localparam int LH = 2, LG = 2, RA = 2;
    localparam int LOADN = 2 * (LH + LG);
    localparam int MAXC = 40000;
    localparam int EV_ERR = 0, EV_SYNC = 1, EV_DONE = 2;
    typedef struct {int kind; int cyc; int idx;} ev_t;
    logic clk = 0;
    logic reset = 1;
    int cyc = 0;
    int tests = 0;
    int fails = 0;
    logic mon_en = 0;
    logic        exp_busy [MAXC];
    logic        exp_load [MAXC];
    logic        exp_rstn [MAXC];
    logic [7:0]  exp_idx  [MAXC];
    logic [15:0] exp_data [MAXC];
    ev_t q[$];
    q_bridge_sequencer_if sb();
    q_bridge_sequencer #(.LOAD_HIGH(LH), .LOAD_GAP(LG), .REARM(RA)) dut (.clk(clk), .reset(reset), .bus(sb));
    always #5 clk = ~clk;
    function automatic void chk(string n, logic [31:0] got, logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", n, cyc, got, want);
        end
    endfunction
    function automatic void set(int x, logic b, logic l, logic r, int i, logic [15:0] d);
        if (x < MAXC) begin
            exp_busy[x] = b;
            exp_load[x] = l;
            exp_rstn[x] = r;
            exp_idx[x]  = 8'(i);
            exp_data[x] = d;
        end
    endfunction
    function automatic void plan(int s, logic [15:0] w, int c, int p);
        int r0 = s + 1 + LOADN;
        for (int k = 1; k <= LOADN; k++) set(s + k, 1, ((k - 1) % (LH + LG)) < LH, 0, 0, w);
        for (int e = 0; e < c; e++) begin
            q.push_back('{EV_SYNC, r0 + e * p, e});
            for (int j = 0; j < p; j++) set(r0 + e * p + j, 1, 0, j < p - RA, e, w);
        end
        set(r0 + c * p, 1, 0, 0, c - 1, w);
        q.push_back('{EV_DONE, r0 + c * p, c - 1});
        for (int x = r0 + c * p + 1; x < MAXC; x++) set(x, 0, 0, 0, c - 1, w);
    endfunction
    function automatic void truncate(int a, logic rst);
        ev_t t[$];
        for (int x = a + 1; x < MAXC; x++) set(x, 0, 0, 0, rst ? 0 : int'(exp_idx[a]), rst ? 16'h0 : exp_data[x]);
        foreach (q[i]) if (q[i].cyc <= a) t.push_back(q[i]);
        q = t;
    endfunction
    function automatic bit act_start(logic [15:0] w, int c, int p);
        sb.i_start      = 1;
        sb.i_cfg_word   = w;
        sb.i_cfg_count  = 8'(c);
        sb.i_cfg_period = 16'(p);
        if (exp_busy[cyc] || sb.i_abort) return 0;
        if (c == 0 || p < int'(w[15:10]) + RA + 3) begin
            q.push_back('{EV_ERR, cyc + 1, 0});
            return 0;
        end
        plan(cyc, w, c, p);
        return 1;
    endfunction
    function automatic void act_abort();
        sb.i_abort = 1;
        truncate(cyc, 0);
    endfunction
    function automatic void act_reset();
        reset = 1;
        truncate(cyc, 1);
    endfunction
    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        sb.i_start      = 0;
        sb.i_abort      = 0;
        reset           = 0;
        sb.i_cfg_word   = 16'($urandom);
        sb.i_cfg_count  = 8'($urandom);
        sb.i_cfg_period = 16'($urandom);
        if (cyc >= MAXC - 5) begin
            fails++;
            $display("FAIL cycle_budget cyc=%0d got=running want=finished", cyc);
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $fatal(1, "cycle budget exhausted");
        end
    endtask
    task automatic wait_idle();
        while (exp_busy[cyc]) step();
    endtask
    task automatic got_ev(int kind);
        ev_t e;
        tests++;
        if (q.size() == 0) begin
            fails++;
            $display("FAIL event_unexpected cyc=%0d got=kind%0d want=none", cyc, kind);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.cyc != cyc || (kind != EV_ERR && e.idx != int'(sb.o_echo_idx))) begin
                fails++;
                $display("FAIL event got=kind%0d@%0d idx%0d want=kind%0d@%0d idx%0d",
                         kind, cyc, sb.o_echo_idx, e.kind, e.cyc, e.idx);
            end
        end
    endtask
    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy", 32'(sb.o_busy), 32'(exp_busy[cyc]));
            chk("pg_load", 32'(sb.o_pg_load), 32'(exp_load[cyc]));
            chk("pg_rst_n", 32'(sb.o_pg_rst_n), 32'(exp_rstn[cyc]));
            chk("echo_idx", 32'(sb.o_echo_idx), 32'(exp_idx[cyc]));
            chk("pg_datain", 32'(sb.o_pg_datain), 32'(exp_data[cyc]));
            if (sb.o_err !== 1'b0) got_ev(EV_ERR);
            if (sb.o_sync !== 1'b0) got_ev(EV_SYNC);
            if (sb.o_done !== 1'b0) got_ev(EV_DONE);
        end
    end
    initial begin
        int s, c, p, t_len, ms, ab;
        logic [15:0] w;
        for (int x = 0; x < MAXC; x++) set(x, 0, 0, 0, 0, 16'h0);
        sb.i_start = 0;
        sb.i_abort = 0;
        sb.i_cfg_word = 0;
        sb.i_cfg_count = 0;
        sb.i_cfg_period = 0;
        repeat (3) begin
            reset = 1;
            step();
        end
        mon_en = 1;
        repeat (2) step();
        void'(act_start(16'h0C53, 3, 40));
        step();
        wait_idle();
        repeat (2) step();
        void'(act_start(16'h1234, 0, 40));
        repeat (3) step();
        void'(act_start(16'h5000, 1, 24));
        repeat (3) step();
        void'(act_start(16'h5000, 1, 25));
        step();
        wait_idle();
        step();
        act_abort();
        void'(act_start(16'h0C53, 2, 30));
        repeat (3) step();
        s = cyc;
        void'(act_start(16'h0C53, 5, 30));
        step();
        while (cyc < s + 1 + LOADN + 30) step();
        act_abort();
        step();
        wait_idle();
        step();
        void'(act_start(16'h0453, 2, 20));
        step();
        wait_idle();
        step();
        void'(act_start(16'h0C53, 3, 40));
        repeat (21) step();
        void'(act_start(16'h0000, 2, 12));
        step();
        wait_idle();
        step();
        void'(act_start(16'h0C53, 2, 30));
        repeat (3) step();
        act_reset();
        repeat (2) step();
        void'(act_start(16'h0C53, 2, 30));
        step();
        wait_idle();
        for (int it = 0; it < 30; it++) begin
            repeat ($urandom_range(0, 3)) step();
            w = 16'($urandom);
            w[15:10] = 6'($urandom_range(0, 30));
            c = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4));
            p = int'($urandom_range(5, 60));
            if (act_start(w, c, p)) begin
                t_len = LOADN + c * p + 1;
                ms = int'($urandom_range(1, t_len));
                ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, t_len)) : 0;
                step();
                for (int k = 1; k <= t_len; k++) begin
                    if (k == ab) act_abort();
                    else if (k == ms) void'(act_start(16'($urandom), 1, int'($urandom_range(5, 60))));
                    step();
                end
            end else begin
                step();
            end
            wait_idle();
        end
        repeat (5) step();
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL pending_events got=%0d want=0 next=kind%0d@%0d", q.size(), q[0].kind, q[0].cyc);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
